// File: rtl/network_result_streamer.sv
// Snapshots the four unit outputs on each rising edge of done and streams them as a byte frame.
// Define RESULT_ARGMAX_EN to append a signed argmax class byte (17-byte frame instead of 16).
module network_result_streamer (
    input  logic        clk,
    input  logic        reset,
    input  logic        done,
    input  logic [31:0] out0,
    input  logic [31:0] out1,
    input  logic [31:0] out2,
    input  logic [31:0] out3,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_WORDS = 4;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(15);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_LAST  = 2'd2
`ifdef RESULT_ARGMAX_EN
        ,
        S_CLASS = 2'd3
`endif
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] snap [NUM_WORDS];
    logic [CNT_W-1:0]  cnt;
    logic              done_d;

    logic              done_rise;
    logic              capture;
    logic              accept;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [BYTE_W-1:0] next_byte;

    function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                    input logic [1:0] sel);
        logic [BYTE_W-1:0] b;
        case (sel)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // An edge seen in LAST starts a new frame just like one seen in IDLE.
    assign done_rise = done & ~done_d;
    assign capture   = done_rise && (state == S_IDLE || state == S_LAST);
    assign accept    = tx_valid & tx_ready;
    assign cnt_nxt   = cnt + CNT_W'(1);
    assign next_byte = pick_byte(snap[cnt_nxt[3:2]], cnt_nxt[1:0]);

`ifdef RESULT_ARGMAX_EN
    logic [1:0]               argmax_idx;
    logic [1:0]               arg_step;
    logic signed [WORD_W-1:0] arg_best;
    logic                     arg_run;

    // Sequential signed argmax over the snapshot, one compare per cycle; ties keep the lower index.
    always_ff @(posedge clk) begin
        if (reset) begin
            argmax_idx <= 2'd0;
            arg_step   <= 2'd0;
            arg_best   <= '0;
            arg_run    <= 1'b0;
        end else if (capture) begin
            argmax_idx <= 2'd0;
            arg_step   <= 2'd1;
            arg_best   <= $signed(out0);
            arg_run    <= 1'b1;
        end else if (arg_run) begin
            if ($signed(snap[arg_step]) > arg_best) begin
                arg_best   <= $signed(snap[arg_step]);
                argmax_idx <= arg_step;
            end
            arg_step <= arg_step + 2'd1;
            if (arg_step == 2'd3) begin
                arg_run <= 1'b0;
            end
        end
    end
`endif

    // Frame sequencer: capture, byte streaming and overrun tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            done_d   <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                snap[i] <= '0;
            end
        end else begin
            done_d <= done;
            case (state)
                S_IDLE, S_LAST: begin
                    if (capture) begin
                        snap[0]  <= out0;
                        snap[1]  <= out1;
                        snap[2]  <= out2;
                        snap[3]  <= out3;
                        cnt      <= '0;
                        tx_data  <= out0[31:24];
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_SEND;
                    end else begin
                        tx_data  <= '0;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (done_rise) begin
                        overrun <= 1'b1;
                    end
                    if (accept) begin
                        if (cnt == LAST_BYTE) begin
`ifdef RESULT_ARGMAX_EN
                            tx_data <= {6'b0, argmax_idx};
                            state   <= S_CLASS;
`else
                            tx_data  <= '0;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_LAST;
`endif
                        end else begin
                            cnt     <= cnt_nxt;
                            tx_data <= next_byte;
                        end
                    end
                end
`ifdef RESULT_ARGMAX_EN
                S_CLASS: begin
                    if (done_rise) begin
                        overrun <= 1'b1;
                    end
                    if (accept) begin
                        tx_data  <= '0;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_LAST;
                    end
                end
`endif
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_result_streamer.sv
// Directed bench for network_result_streamer: table of frames plus overrun, reset and held-done sequences.
module tb_network_result_streamer;

`ifdef RESULT_ARGMAX_EN
    localparam int FRAME_LEN = 17;
`else
    localparam int FRAME_LEN = 16;
`endif

    logic        clk;
    logic        reset;
    logic        done;
    logic [31:0] out0, out1, out2, out3;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    network_result_streamer dut (
        .clk      (clk),
        .reset    (reset),
        .done     (done),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] words;   // {out0, out1, out2, out3}
        bit           toggle;  // tx_ready pattern 1,0,0,1 instead of constant 1
        logic [1:0]   cls;     // hand-computed signed argmax
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input logic [127:0] w, input bit toggle, input logic [1:0] cls,
                             input int inject_at, input int abort_at, input bit hold,
                             input string nm);
        int         k;
        int         cyc;
        bit         stalled;
        bit         rdy;
        bit         inj;
        bit         injected;
        bit         quit;
        logic [7:0] prev;
        logic [7:0] exp;
        logic [3:0] pat;
        pat      = 4'b1001;
        k        = 0;
        cyc      = 0;
        stalled  = 1'b0;
        inj      = 1'b0;
        injected = 1'b0;
        quit     = 1'b0;
        prev     = 8'h00;
        @(negedge clk);
        {out0, out1, out2, out3} = w;
        done     = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        if (!hold) done = 1'b0;
        chk({nm, " busy at N+1"}, 32'(busy), 32'd1);
        while (k < FRAME_LEN && cyc < 200 && !quit) begin
            if (cyc > 0) @(negedge clk);
            if (inj) begin
                done = 1'b0;
                inj  = 1'b0;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                quit  = 1'b1;
            end else begin
                if (k == inject_at && !injected) begin
                    {out0, out1, out2, out3} = ~w;
                    done     = 1'b1;
                    inj      = 1'b1;
                    injected = 1'b1;
                end
                chk({nm, " valid in frame"}, 32'(tx_valid), 32'd1);
                if (stalled) chk({nm, " stall hold"}, 32'(tx_data), 32'(prev));
                rdy      = toggle ? pat[cyc % 4] : 1'b1;
                tx_ready = rdy;
                if (rdy) begin
                    exp = (k < 16) ? w[127 - 8*k -: 8] : {6'b0, cls};
                    chk($sformatf("%s byte %0d", nm, k), 32'(tx_data), 32'(exp));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev    = tx_data;
                end
                cyc++;
            end
        end
        if (quit) begin
            @(negedge clk);
            chk({nm, " abort valid"},   32'(tx_valid), 32'd0);
            chk({nm, " abort busy"},    32'(busy),     32'd0);
            chk({nm, " abort data"},    32'(tx_data),  32'd0);
            chk({nm, " abort overrun"}, 32'(overrun),  32'd0);
            reset    = 1'b0;
            tx_ready = 1'b1;
        end else begin
            chk({nm, " accepts"}, 32'(k), 32'(FRAME_LEN));
            if (!toggle) chk({nm, " cycles"}, 32'(cyc), 32'(FRAME_LEN));
            @(negedge clk);
            chk({nm, " last valid"}, 32'(tx_valid), 32'd0);
            chk({nm, " last busy"},  32'(busy),     32'd0);
        end
    endtask

    task automatic idle_watch(input int n, input string nm);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_valid || busy) seen++;
        end
        chk({nm, " no extra frame"}, 32'(seen), 32'd0);
    endtask

    initial begin
        vecs[0] = '{128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b0, 2'd1};
        vecs[1] = '{128'h11223344_55667788_99AABBCC_DDEEFF00, 1'b1, 2'd1};
        vecs[2] = '{128'hFFFFFFFB_00000007_00000007_80000000, 1'b0, 2'd1};
        vecs[3] = '{128'h80000000_80000000_80000000_80000000, 1'b1, 2'd0};
        vecs[4] = '{128'h00000001_FFFFFFFF_7FFFFFFF_7FFFFFFF, 1'b0, 2'd2};

        reset    = 1'b1;
        done     = 1'b0;
        tx_ready = 1'b0;
        {out0, out1, out2, out3} = 128'h0;
        repeat (3) @(negedge clk);
        chk("reset tx_data",  32'(tx_data),  32'd0);
        chk("reset tx_valid", 32'(tx_valid), 32'd0);
        chk("reset busy",     32'(busy),     32'd0);
        chk("reset overrun",  32'(overrun),  32'd0);

        // done already high in the first cycle after reset counts as an edge
        done = 1'b1;
        out0 = 32'hA1B2C3D4;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset edge valid", 32'(tx_valid), 32'd1);
        chk("post-reset edge data",  32'(tx_data),  32'hA1);
        reset = 1'b1;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].words, vecs[i].toggle, vecs[i].cls, -1, -1, 1'b0,
                      $sformatf("vec%0d", i));
            @(negedge clk);
        end
        chk("no overrun after clean frames", 32'(overrun), 32'd0);

        run_frame(vecs[0].words, 1'b0, vecs[0].cls, 5, -1, 1'b0, "overrun");
        chk("overrun set", 32'(overrun), 32'd1);
        idle_watch(20, "overrun");
        chk("overrun sticky", 32'(overrun), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("overrun cleared by reset", 32'(overrun), 32'd0);

        run_frame(vecs[2].words, 1'b0, vecs[2].cls, -1, 8, 1'b0, "midreset");
        @(negedge clk);
        run_frame(vecs[4].words, 1'b0, vecs[4].cls, -1, -1, 1'b0, "after reset");

        run_frame(vecs[0].words, 1'b0, vecs[0].cls, -1, -1, 1'b1, "held done");
        idle_watch(30, "held done");
        chk("held done overrun", 32'(overrun), 32'd0);
        done = 1'b0;
        run_frame(vecs[3].words, 1'b0, vecs[3].cls, -1, -1, 1'b0, "re-rise");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
